// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Boot-time program loader fed by a UART receiver. Bytes are packed MSB
//   first into WORD_BYTES-wide words, which are written to memory from
//   LOAD_BASE upwards. A terminator word ends the image. One checksum byte
//   follows it, and the image bytes plus the checksum must sum to 0 mod 256.
//   A bad checksum or an oversized image restarts the attempt. Once the
//   image is accepted the block stays in RUN until reset. In RUN, received
//   bytes are queued in a small RX FIFO that the CPU drains.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx_prog             at reset: 1 = expect an image, 0 = go straight to RUN
//   rx_byte, rx_v       received byte and its one-cycle valid strobe
//   mem_addr/_wdata/_wr memory write port (one-cycle write strobe)
//   load_done           high in RUN (CPU is held in reset while low)
//   load_err            last load attempt failed
//   pop                 CPU consumes the FIFO head
//   fifo_data           registered FIFO head, valid while fifo_count != 0
//   fifo_count          number of bytes held
//   fifo_ovf, ovf_clr   sticky overflow flag and its clear
module uart_prog_loader #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WORD_BYTES  = 2,
    parameter int          LOAD_BASE   = 'h300,
    parameter int          LIMIT_WORDS = 256,
    parameter int unsigned TERM_WORD   = 'h7fff,
    parameter int          TIMEOUT_CYC = 27000,
    parameter int          DEPTH       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_prog,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_v,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [8*WORD_BYTES-1:0]   mem_wdata,
    output logic                      mem_wr,
    output logic                      load_done,
    output logic                      load_err,
    input  logic                      pop,
    output logic [7:0]                fifo_data,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      fifo_ovf,
    input  logic                      ovf_clr
);

    localparam int W        = 8 * WORD_BYTES;
    localparam int PH_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int IDX_W    = $clog2(LIMIT_WORDS + 1);
    localparam int TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    localparam logic [W-1:0]          TERM    = W'(TERM_WORD);
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [PH_W-1:0]       PH_LAST = PH_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CSUM,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [W-1:0]            word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              sum_q, sum_d;
    logic [IDX_W-1:0]        widx_q, widx_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    err_q, err_d;
    logic                    wr_q, wr_d;
    logic [W-1:0]            wdata_q, wdata_d;

    logic [W-1:0]            word_shift;
    logic [7:0]              csum_exp;
    logic [7:0]              byte_sum;
    logic                    load_fail;

    logic [7:0]              fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]        rd_q, rd_d;
    logic [PTR_W-1:0]        wp_q, wp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_after_pop;
    logic                    ovf_q, ovf_d;
    logic [7:0]              head_q, head_d;
    logic                    pop_eff, push_req, push_ok, full;

    // Shifting in MSB first; the oldest byte falls off the top.
    assign word_shift = W'({word_q, rx_byte});
    assign csum_exp   = 8'(~sum_q + 8'd1);

    // The loader state register. rx_prog decides at reset whether an image
    // is expected, so load_done already shows the right level during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= rx_prog ? ST_LOAD : ST_RUN;
            phase_q <= '0;
            word_q  <= '0;
            addr_q  <= BASE;
            sum_q   <= '0;
            widx_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            widx_q  <= widx_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // Loader next state. The address, running sum and word count advance
    // in the write cycle. Because rx_v is never back to back, no byte can
    // arrive before they are up to date.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        word_d    = word_q;
        addr_d    = addr_q;
        sum_d     = sum_q;
        widx_d    = widx_q;
        timer_d   = '0;
        err_d     = err_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        load_fail = 1'b0;

        byte_sum = sum_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            byte_sum = byte_sum + wdata_q[8*i +: 8];
        end

        if (wr_q) begin
            addr_d = addr_q + ADDR_WIDTH'(WORD_BYTES);
            sum_d  = byte_sum;
            widx_d = widx_q + IDX_W'(1);
        end

        // A stalled partial word is dropped after TIMEOUT_CYC idle cycles.
        if (TIMEOUT_CYC != 0 && state_q == ST_LOAD && !rx_v && phase_q != '0) begin
            if (timer_q == TMR_W'(TMO_LAST)) begin
                phase_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end

        if (rx_v) begin
            unique case (state_q)
                ST_LOAD: begin
                    if (phase_q == '0 && addr_q == BASE) begin
                        err_d = 1'b0;
                    end
                    word_d = word_shift;
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (word_shift == TERM) begin
                            state_d = ST_CSUM;
                        end else if (widx_q == IDX_W'(LIMIT_WORDS)) begin
                            load_fail = 1'b1;
                        end else begin
                            wr_d    = 1'b1;
                            wdata_d = word_shift;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                ST_CSUM: begin
                    if (rx_byte == csum_exp) begin
                        state_d = ST_RUN;
                    end else begin
                        load_fail = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // A failed attempt restarts from the base address with a clean sum.
        if (load_fail) begin
            err_d   = 1'b1;
            state_d = ST_LOAD;
            addr_d  = BASE;
            sum_d   = '0;
            phase_d = '0;
            widx_d  = '0;
        end
    end

    // FIFO storage needs no reset; only entries below fifo_count are read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wp_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            head_q <= head_d;
        end
    end

    // FIFO control. When the FIFO is full, a push in the same cycle as a pop
    // reuses the slot that the pop frees. The registered head takes the
    // pushed byte directly if that byte becomes the only entry.
    always_comb begin
        full          = (cnt_q == CNT_W'(DEPTH));
        pop_eff       = pop && (cnt_q != '0);
        push_req      = rx_v && (state_q == ST_RUN);
        push_ok       = push_req && (!full || pop_eff);
        rd_d          = rd_q + PTR_W'(pop_eff);
        wp_d          = wp_q + PTR_W'(push_ok);
        cnt_after_pop = cnt_q - CNT_W'(pop_eff);
        cnt_d         = cnt_after_pop + CNT_W'(push_ok);

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end

        head_d = head_q;
        if (push_ok && cnt_after_pop == '0) begin
            head_d = rx_byte;
        end else if (pop_eff && cnt_after_pop != '0) begin
            head_d = fifo_mem_q[rd_d];
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wr     = wr_q;
    assign load_done  = (state_q == ST_RUN);
    assign load_err   = err_q;
    assign fifo_data  = head_q;
    assign fifo_count = cnt_q;
    assign fifo_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader
//   Self-checking bench for uart_prog_loader. A behavioural model of the
//   loader and FIFO (queues, plain arithmetic) is advanced on every clock
//   edge. One compare process checks all outputs against it at each falling
//   edge. Directed scenarios add literal expectations, and randomized rounds
//   follow.
module tb_uart_prog_loader;

    localparam int AW    = 10;
    localparam int WB    = 2;
    localparam int BASE  = 'h300;
    localparam int LIMIT = 2;
    localparam int TERM  = 'h7fff;
    localparam int TMO   = 50;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rx_prog = 1'b1;
    logic [7:0]      rx_byte = '0;
    logic            rx_v = 1'b0;
    logic            pop = 1'b0;
    logic            ovf_clr = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic [8*WB-1:0] mem_wdata;
    logic            mem_wr;
    logic            load_done;
    logic            load_err;
    logic [7:0]      fifo_data;
    logic [CW-1:0]   fifo_count;
    logic            fifo_ovf;

    uart_prog_loader #(
        .ADDR_WIDTH (AW),
        .WORD_BYTES (WB),
        .LOAD_BASE  (BASE),
        .LIMIT_WORDS(LIMIT),
        .TERM_WORD  (TERM),
        .TIMEOUT_CYC(TMO),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_prog   (rx_prog),
        .rx_byte   (rx_byte),
        .rx_v      (rx_v),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .load_done (load_done),
        .load_err  (load_err),
        .pop       (pop),
        .fifo_data (fifo_data),
        .fifo_count(fifo_count),
        .fifo_ovf  (fifo_ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model of what the loader must be doing
    typedef enum {M_LOAD, M_CSUM, M_RUN} mode_t;
    mode_t       m_mode = M_LOAD;
    int          m_nbytes = 0;
    int unsigned m_word = 0;
    int          m_addr = BASE;
    int          m_sum = 0;
    int          m_nwords = 0;
    int          m_idle = 0;
    bit          m_err = 1'b0;
    bit          m_ovf = 1'b0;
    logic [7:0]  m_fifo[$];
    bit          exp_wr = 1'b0;
    int          exp_waddr = 0;
    int          exp_wdata = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t wr_log[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset(input bit prog);
        m_mode   = prog ? M_LOAD : M_RUN;
        m_nbytes = 0;
        m_word   = 0;
        m_addr   = BASE;
        m_sum    = 0;
        m_nwords = 0;
        m_idle   = 0;
        m_err    = 1'b0;
        m_ovf    = 1'b0;
        m_fifo.delete();
        exp_wr   = 1'b0;
    endtask

    task automatic modelError();
        m_err    = 1'b1;
        m_mode   = M_LOAD;
        m_addr   = BASE;
        m_sum    = 0;
        m_nbytes = 0;
        m_nwords = 0;
    endtask

    // One clock edge of the model, using the inputs presented at that edge
    task automatic modelStep();
        int unsigned mask = (32'd1 << (8 * WB)) - 1;
        exp_wr = 1'b0;
        if (pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (ovf_clr) m_ovf = 1'b0;
        if (rx_v) begin
            case (m_mode)
                M_LOAD: begin
                    if (m_nbytes > 0 && TMO > 0 && m_idle >= TMO) m_nbytes = 0;
                    if (m_nbytes == 0 && m_addr == BASE) m_err = 1'b0;
                    m_word = ((m_word << 8) | rx_byte) & mask;
                    m_nbytes++;
                    if (m_nbytes == WB) begin
                        m_nbytes = 0;
                        if (m_word == (TERM & mask)) begin
                            m_mode = M_CSUM;
                        end else if (m_nwords == LIMIT) begin
                            modelError();
                        end else begin
                            exp_wr    = 1'b1;
                            exp_waddr = m_addr;
                            exp_wdata = int'(m_word);
                            m_addr    = (m_addr + WB) % (1 << AW);
                            m_nwords++;
                            for (int k = 0; k < WB; k++)
                                m_sum = (m_sum + int'((m_word >> (8 * k)) & 255)) % 256;
                        end
                    end
                end
                M_CSUM: begin
                    if ((m_sum + int'(rx_byte)) % 256 == 0) m_mode = M_RUN;
                    else modelError();
                end
                default: begin
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(rx_byte);
                    else m_ovf = 1'b1;
                end
            endcase
            m_idle = 0;
        end else begin
            m_idle++;
        end
    endtask

    // Compare process: every falling edge out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr === 1'b1) wr_log.push_back('{addr: int'(mem_addr), data: int'(mem_wdata)});
            checkOutput("mem_wr", mem_wr, exp_wr);
            checkOutput("mem_addr", mem_addr, exp_wr ? exp_waddr : m_addr);
            if (exp_wr) checkOutput("mem_wdata", mem_wdata, exp_wdata);
            checkOutput("load_done", load_done, m_mode == M_RUN);
            checkOutput("load_err", load_err, m_err);
            checkOutput("fifo_count", fifo_count, m_fifo.size());
            checkOutput("fifo_ovf", fifo_ovf, m_ovf);
            if (m_fifo.size() != 0) checkOutput("fifo_data", fifo_data, m_fifo[0]);
        end
    end

    // Drive one cycle; inputs change only 1 time unit after the rising edge
    task automatic applyStimulus(input bit v, input logic [7:0] b, input bit p, input bit c);
        rx_v    = v;
        rx_byte = b;
        pop     = p;
        ovf_clr = c;
        @(posedge clk);
        modelStep();
        #1;
        rx_v    = 1'b0;
        pop     = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // gap = idle cycles between the previous strobe and this one
    task automatic sendByte(input logic [7:0] b, input int gap);
        idle(gap);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic sendBytes(input logic [7:0] bs[$], input int gap);
        foreach (bs[i]) sendByte(bs[i], gap);
    endtask

    // Asynchronous reset mid-cycle, with the reset values checked while it is held
    task automatic resetDut(input bit prog);
        #2;
        rx_prog = prog;
        rst_n   = 1'b0;
        modelReset(prog);
        #1;
        checkOutput("rst_mem_wr", mem_wr, 0);
        checkOutput("rst_mem_addr", mem_addr, BASE);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_load_err", load_err, 0);
        checkOutput("rst_load_done", load_done, !prog);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_fifo_ovf", fifo_ovf, 0);
        checkOutput("rst_fifo_data", fifo_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic sendRandom(input logic [7:0] b);
        int r = $urandom_range(0, 19);
        int gap;
        if (r == 0) gap = TMO - 1;
        else if (r == 1) gap = TMO;
        else if (r == 2) gap = TMO + $urandom_range(1, 5);
        else gap = $urandom_range(1, 4);
        repeat (gap)
            applyStimulus(1'b0, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        applyStimulus(1'b1, b, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    endtask

    task automatic randomRound();
        logic [7:0] s[$];
        int attempts = $urandom_range(1, 2);
        int nf;
        for (int a = 0; a < attempts; a++) begin
            int nw = $urandom_range(0, 3);
            int sum = 0;
            logic [7:0] cs;
            for (int w = 0; w < nw; w++) begin
                int word;
                do word = $urandom_range(0, 65535); while (word == TERM);
                s.push_back(8'(word >> 8));
                s.push_back(8'(word));
                sum += (word >> 8) + (word & 255);
            end
            s.push_back(8'(TERM >> 8));
            s.push_back(8'(TERM));
            cs = 8'(256 - (sum % 256));
            if ($urandom_range(0, 3) == 0) cs = cs + 8'd1;
            s.push_back(cs);
        end
        nf = $urandom_range(0, 20);
        for (int i = 0; i < nf; i++) s.push_back(8'($urandom));
        foreach (s[i]) sendRandom(s[i]);
        idle(3);
    endtask

    initial begin
        logic [7:0] img[$];

        // Good image: checksum 0x42 = -(12+34+AB+CD) mod 256
        resetDut(1'b1);
        wr_log.delete();
        img = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h7F, 8'hFF, 8'h42};
        sendBytes(img, 2);
        idle(3);
        checkOutput("t1_nwrites", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            checkOutput("t1_addr0", wr_log[0].addr, 'h300);
            checkOutput("t1_data0", wr_log[0].data, 'h1234);
            checkOutput("t1_addr1", wr_log[1].addr, 'h302);
            checkOutput("t1_data1", wr_log[1].data, 'hABCD);
        end
        checkOutput("t1_done", load_done, 1);
        checkOutput("t1_err", load_err, 0);

        // Bad checksum, then retry
        resetDut(1'b1);
        img = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h7F, 8'hFF, 8'h00};
        sendBytes(img, 2);
        idle(3);
        checkOutput("t2_err", load_err, 1);
        checkOutput("t2_done", load_done, 0);
        checkOutput("t2_addr", mem_addr, 'h300);
        sendByte(8'h12, 2);
        checkOutput("t2_err_clr", load_err, 0);
        img = '{8'h34, 8'hAB, 8'hCD, 8'h7F, 8'hFF, 8'h42};
        sendBytes(img, 2);
        idle(3);
        checkOutput("t2_done2", load_done, 1);

        // Timeout discards a partial word; one cycle short keeps it
        resetDut(1'b1);
        wr_log.delete();
        sendByte(8'h12, 2);
        sendByte(8'h56, TMO + 1);
        sendByte(8'h78, 2);
        idle(3);
        sendByte(8'h9A, 2);
        sendByte(8'hBC, TMO - 1);
        idle(3);
        checkOutput("t3_nwrites", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            checkOutput("t3_addr0", wr_log[0].addr, 'h300);
            checkOutput("t3_data0", wr_log[0].data, 'h5678);
            checkOutput("t3_addr1", wr_log[1].addr, 'h302);
            checkOutput("t3_data1", wr_log[1].data, 'h9ABC);
        end

        // Limit of two words: third data word errors with no write
        resetDut(1'b1);
        wr_log.delete();
        img = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        sendBytes(img, 2);
        idle(3);
        checkOutput("t4_nwrites", wr_log.size(), 2);
        checkOutput("t4_err", load_err, 1);
        checkOutput("t4_addr", mem_addr, 'h300);

        // Skip straight to RUN, overflow and drain the FIFO
        resetDut(1'b0);
        idle(1);
        checkOutput("t5_done", load_done, 1);
        for (int i = 1; i <= DEPTH + 1; i++) sendByte(8'(i), 1);
        idle(2);
        checkOutput("t5_count", fifo_count, DEPTH);
        checkOutput("t5_ovf", fifo_ovf, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            checkOutput("t5_pop_data", fifo_data, i);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("t5_empty", fifo_count, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t5_ovf_clr", fifo_ovf, 0);

        // Full FIFO: push+pop together, then drop+clear together
        for (int i = 0; i < DEPTH; i++) sendByte(8'hA0 + 8'(i), 1);
        idle(1);
        checkOutput("t6_full", fifo_count, DEPTH);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("t6_count", fifo_count, DEPTH);
        checkOutput("t6_ovf", fifo_ovf, 0);
        checkOutput("t6_head", fifo_data, 8'hA1);
        idle(1);
        applyStimulus(1'b1, 8'hDD, 1'b0, 1'b1);
        checkOutput("t6_ovf_wins", fifo_ovf, 1);

        // Reset during a write cycle
        resetDut(1'b1);
        sendByte(8'h12, 2);
        sendByte(8'h34, 2);
        checkOutput("t7_wr_before", mem_wr, 1);
        wr_log.delete();
        resetDut(1'b1);
        idle(5);
        checkOutput("t7_no_write", wr_log.size(), 0);

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            resetDut($urandom_range(0, 3) != 0);
            randomRound();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
